// File: rtl/decode_stage.sv
// Instruction-decode stage of the 16-bit pipelined MIPS: field decode, control
// generation, 8x16 register file with write-through bypass, load-use hazard
// detection and the ID/EX pipeline register feeding execute.
module decode_stage #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr_pipe_1,
  input  logic [DATA_W-1:0] pc_plus_2_pipe_1,
  input  logic              flush,
  input  logic              regWrite_wb,
  input  logic [2:0]        write_reg_wb,
  input  logic [DATA_W-1:0] write_data_wb,
  output logic              stall,
  output logic [DATA_W-1:0] pc_plus_2_out_pipe_2,
  output logic [DATA_W-1:0] read_data_1_out_pipe_2,
  output logic [DATA_W-1:0] read_data_2_out_pipe_2,
  output logic [DATA_W-1:0] sign_extended_imm_out_pipe_2,
  output logic [2:0]        rs_pipe_2,
  output logic [2:0]        rt_pipe_2,
  output logic [2:0]        rd_pipe_2,
  output logic              aluSrc,
  output logic              regDst,
  output logic              memRead,
  output logic              memWrite,
  output logic              memToReg,
  output logic              regWrite,
  output logic              branch,
  output logic [1:0]        aluOp
);

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_LW    = 4'b1011;
  localparam logic [3:0] OP_SW    = 4'b1111;
  localparam logic [3:0] OP_BEQ   = 4'b1000;

  logic [3:0]        opcode;
  logic [2:0]        rs, rt, rd;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] read_data_1, read_data_2;
  logic [DATA_W-1:0] regs [REG_N];

  logic dec_alu_src, dec_reg_dst, dec_mem_read, dec_mem_write;
  logic dec_mem_to_reg, dec_reg_write, dec_branch;
  logic [1:0] dec_alu_op;
  logic uses_rt, load_use, bubble;

  assign opcode  = instr_pipe_1[15:12];
  assign rs      = instr_pipe_1[11:9];
  assign rt      = instr_pipe_1[8:6];
  assign rd      = instr_pipe_1[5:3];
  assign imm_ext = {{(DATA_W-6){instr_pipe_1[5]}}, instr_pipe_1[5:0]};

  // Control decode from the opcode; unknown opcodes decode as a NOP.
  always_comb begin
    dec_alu_src    = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_reg_write  = 1'b0;
    dec_branch     = 1'b0;
    dec_alu_op     = 2'b00;
    uses_rt        = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_reg_dst   = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_op    = 2'b10;
        uses_rt       = 1'b1;
      end
      OP_ADDI: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_LW: begin
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_reg_write  = 1'b1;
      end
      OP_SW: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        dec_branch = 1'b1;
        dec_alu_op = 2'b01;
        uses_rt    = 1'b1;
      end
      default: ;
    endcase
  end

  // Register-file read ports: r0 is hardwired to zero, a same-cycle WB write bypasses the array.
  always_comb begin
    read_data_1 = regs[rs];
    read_data_2 = regs[rt];
    if (rs == 3'd0) begin
      read_data_1 = '0;
    end else if (regWrite_wb && (write_reg_wb == rs)) begin
      read_data_1 = write_data_wb;
    end
    if (rt == 3'd0) begin
      read_data_2 = '0;
    end else if (regWrite_wb && (write_reg_wb == rt)) begin
      read_data_2 = write_data_wb;
    end
  end

  // Register-file write port from WB; writes to r0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (regWrite_wb && (write_reg_wb != 3'd0)) begin
      regs[write_reg_wb] <= write_data_wb;
    end
  end

  // A load in ID/EX whose destination feeds this instruction must wait one cycle.
  assign load_use = memRead && (rt_pipe_2 != 3'd0) &&
                    ((rt_pipe_2 == rs) || ((rt_pipe_2 == rt) && uses_rt));
  assign stall    = load_use && !flush;
  assign bubble   = flush || load_use;

  // ID/EX pipeline register: bubble on flush or load-use, otherwise capture the decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bubble) begin
      pc_plus_2_out_pipe_2         <= '0;
      read_data_1_out_pipe_2       <= '0;
      read_data_2_out_pipe_2       <= '0;
      sign_extended_imm_out_pipe_2 <= '0;
      rs_pipe_2                    <= '0;
      rt_pipe_2                    <= '0;
      rd_pipe_2                    <= '0;
      aluSrc                       <= 1'b0;
      regDst                       <= 1'b0;
      memRead                      <= 1'b0;
      memWrite                     <= 1'b0;
      memToReg                     <= 1'b0;
      regWrite                     <= 1'b0;
      branch                       <= 1'b0;
      aluOp                        <= 2'b00;
    end else begin
      pc_plus_2_out_pipe_2         <= pc_plus_2_pipe_1;
      read_data_1_out_pipe_2       <= read_data_1;
      read_data_2_out_pipe_2       <= read_data_2;
      sign_extended_imm_out_pipe_2 <= imm_ext;
      rs_pipe_2                    <= rs;
      rt_pipe_2                    <= rt;
      rd_pipe_2                    <= rd;
      aluSrc                       <= dec_alu_src;
      regDst                       <= dec_reg_dst;
      memRead                      <= dec_mem_read;
      memWrite                     <= dec_mem_write;
      memToReg                     <= dec_mem_to_reg;
      regWrite                     <= dec_reg_write;
      branch                       <= dec_branch;
      aluOp                        <= dec_alu_op;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: expected ID/EX contents are queued as each instruction
// is presented and compared after the capturing clock edge.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr_pipe_1;
  logic [15:0] pc_plus_2_pipe_1;
  logic        flush;
  logic        regWrite_wb;
  logic [2:0]  write_reg_wb;
  logic [15:0] write_data_wb;
  logic        stall;
  logic [15:0] pc_plus_2_out_pipe_2, read_data_1_out_pipe_2;
  logic [15:0] read_data_2_out_pipe_2, sign_extended_imm_out_pipe_2;
  logic [2:0]  rs_pipe_2, rt_pipe_2, rd_pipe_2;
  logic        aluSrc, regDst, memRead, memWrite, memToReg, regWrite, branch;
  logic [1:0]  aluOp;
  logic [8:0]  dut_ctrl;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [8:0]  ctrl;
  } exp_t;

  // ctrl = {aluSrc, regDst, memRead, memWrite, memToReg, regWrite, branch, aluOp}
  localparam logic [8:0] C_R    = 9'b0_1_0_0_0_1_0_10;
  localparam logic [8:0] C_ADDI = 9'b1_0_0_0_0_1_0_00;
  localparam logic [8:0] C_LW   = 9'b1_0_1_0_1_1_0_00;
  localparam logic [8:0] C_SW   = 9'b1_0_0_1_0_0_0_00;
  localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_0_1_01;
  localparam exp_t BUBBLE = '0;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  assign dut_ctrl = {aluSrc, regDst, memRead, memWrite, memToReg, regWrite, branch, aluOp};

  decode_stage #(.DATA_W(16), .REG_N(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_pipe_1(instr_pipe_1),
    .pc_plus_2_pipe_1(pc_plus_2_pipe_1),
    .flush(flush),
    .regWrite_wb(regWrite_wb),
    .write_reg_wb(write_reg_wb),
    .write_data_wb(write_data_wb),
    .stall(stall),
    .pc_plus_2_out_pipe_2(pc_plus_2_out_pipe_2),
    .read_data_1_out_pipe_2(read_data_1_out_pipe_2),
    .read_data_2_out_pipe_2(read_data_2_out_pipe_2),
    .sign_extended_imm_out_pipe_2(sign_extended_imm_out_pipe_2),
    .rs_pipe_2(rs_pipe_2),
    .rt_pipe_2(rt_pipe_2),
    .rd_pipe_2(rd_pipe_2),
    .aluSrc(aluSrc),
    .regDst(regDst),
    .memRead(memRead),
    .memWrite(memWrite),
    .memToReg(memToReg),
    .regWrite(regWrite),
    .branch(branch),
    .aluOp(aluOp)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [15:0] pc, rd1, rd2, imm,
                              input logic [2:0] rs, rt, rd, input logic [8:0] ctrl);
    exp_t e;
    e.pc = pc; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
    e.rs = rs; e.rt = rt; e.rd = rd; e.ctrl = ctrl;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic compareAll(input string tag, input exp_t e);
    checkOutput({tag, ".pc"},   pc_plus_2_out_pipe_2, e.pc);
    checkOutput({tag, ".rd1"},  read_data_1_out_pipe_2, e.rd1);
    checkOutput({tag, ".rd2"},  read_data_2_out_pipe_2, e.rd2);
    checkOutput({tag, ".imm"},  sign_extended_imm_out_pipe_2, e.imm);
    checkOutput({tag, ".rs"},   {13'd0, rs_pipe_2}, {13'd0, e.rs});
    checkOutput({tag, ".rt"},   {13'd0, rt_pipe_2}, {13'd0, e.rt});
    checkOutput({tag, ".rd"},   {13'd0, rd_pipe_2}, {13'd0, e.rd});
    checkOutput({tag, ".ctrl"}, {7'd0, dut_ctrl}, {7'd0, e.ctrl});
  endtask

  // Present one instruction (plus optional WB write) for a cycle; called just after a rising edge.
  task automatic applyStimulus(input string tag, input logic [15:0] instr, pc,
                               input logic fl, wb_en, input logic [2:0] wb_reg,
                               input logic [15:0] wb_data, input logic exp_stall,
                               input exp_t e);
    exp_t got;
    instr_pipe_1     = instr;
    pc_plus_2_pipe_1 = pc;
    flush            = fl;
    regWrite_wb      = wb_en;
    write_reg_wb     = wb_reg;
    write_data_wb    = wb_data;
    sb.push_back(e);
    #1;
    checkOutput({tag, ".stall"}, {15'd0, stall}, {15'd0, exp_stall});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL %s.queue: got empty expected entry", tag);
    end else begin
      got = sb.pop_front();
      compareAll(tag, got);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    instr_pipe_1     = 16'h2000;
    pc_plus_2_pipe_1 = '0;
    flush            = 1'b0;
    regWrite_wb      = 1'b0;
    write_reg_wb     = '0;
    write_data_wb    = '0;
    repeat (2) @(posedge clk);
    #1;
    compareAll("reset", BUBBLE);
    checkOutput("reset.stall", {15'd0, stall}, 16'd0);
    rst_n = 1'b1;

    // Write-back r1=3, r2=1 under NOPs, then add r3,r1,r2.
    applyStimulus("wb_r1", 16'h2000, 16'd0, 1'b0, 1'b1, 3'd1, 16'd3, 1'b0, BUBBLE);
    applyStimulus("wb_r2", 16'h2000, 16'd0, 1'b0, 1'b1, 3'd2, 16'd1, 1'b0, BUBBLE);
    applyStimulus("add", 16'h0298, 16'd2, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd2, 16'd3, 16'd1, 16'h0018, 3'd1, 3'd2, 3'd3, C_R));

    // lw r2,-2(r1) then dependent add: one stall cycle with bubble, then the add issues.
    applyStimulus("lw", 16'hB2BE, 16'd4, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd4, 16'd3, 16'd1, 16'hFFFE, 3'd1, 3'd2, 3'd7, C_LW));
    applyStimulus("lu_stall", 16'h0298, 16'd6, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, BUBBLE);
    applyStimulus("lu_issue", 16'h0298, 16'd6, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd6, 16'd3, 16'd1, 16'h0018, 3'd1, 3'd2, 3'd3, C_R));

    // Same-cycle bypass of r1, then a write to r0 while reading r0.
    applyStimulus("byp_r1", 16'h0298, 16'd8, 1'b0, 1'b1, 3'd1, 16'h1234, 1'b0,
                  mk(16'd8, 16'h1234, 16'd1, 16'h0018, 3'd1, 3'd2, 3'd3, C_R));
    applyStimulus("byp_r0", 16'h0098, 16'd10, 1'b0, 1'b1, 3'd0, 16'hBEEF, 1'b0,
                  mk(16'd10, 16'd0, 16'd1, 16'h0018, 3'd0, 3'd2, 3'd3, C_R));
    applyStimulus("r0_kept", 16'h0218, 16'd12, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd12, 16'h1234, 16'd0, 16'h0018, 3'd1, 3'd0, 3'd3, C_R));

    // Flush overrides load-use.
    applyStimulus("lw2", 16'hB2BE, 16'd14, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd14, 16'h1234, 16'd1, 16'hFFFE, 3'd1, 3'd2, 3'd7, C_LW));
    applyStimulus("flush", 16'h0298, 16'd16, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, BUBBLE);
    applyStimulus("post_flush", 16'h0298, 16'd16, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd16, 16'h1234, 16'd1, 16'h0018, 3'd1, 3'd2, 3'd3, C_R));

    // addi rt matches the load but addi does not read rt: no stall. Then sw, beq.
    applyStimulus("lw3", 16'hB2BE, 16'd18, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd18, 16'h1234, 16'd1, 16'hFFFE, 3'd1, 3'd2, 3'd7, C_LW));
    applyStimulus("addi", 16'h4283, 16'd20, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd20, 16'h1234, 16'd1, 16'h0003, 3'd1, 3'd2, 3'd0, C_ADDI));
    applyStimulus("sw", 16'hF2BE, 16'd22, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd22, 16'h1234, 16'd1, 16'hFFFE, 3'd1, 3'd2, 3'd7, C_SW));
    applyStimulus("beq", 16'h8298, 16'd24, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd24, 16'h1234, 16'd1, 16'h0018, 3'd1, 3'd2, 3'd3, C_BEQ));

    // A load into r0 never creates a hazard.
    applyStimulus("lw_r0", 16'hB03E, 16'd26, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd26, 16'd0, 16'd0, 16'hFFFE, 3'd0, 3'd0, 3'd7, C_LW));
    applyStimulus("after_lw_r0", 16'h0098, 16'd28, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd28, 16'd0, 16'd1, 16'h0018, 3'd0, 3'd2, 3'd3, C_R));

    // rs-only dependence stalls; reset asserted mid-stall clears everything.
    applyStimulus("lw4", 16'hB2BE, 16'd30, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd30, 16'h1234, 16'd1, 16'hFFFE, 3'd1, 3'd2, 3'd7, C_LW));
    instr_pipe_1     = 16'h44C1;
    pc_plus_2_pipe_1 = 16'd32;
    #1;
    checkOutput("rs_dep.stall", {15'd0, stall}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    compareAll("mid_rst", BUBBLE);
    checkOutput("mid_rst.stall", {15'd0, stall}, 16'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("post_rst", 16'h0298, 16'd34, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0,
                  mk(16'd34, 16'd0, 16'd0, 16'h0018, 3'd1, 3'd2, 3'd3, C_R));

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard: got %0d leftover entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the 16-bit pipelined MIPS. It sits between the IF/ID register and the execute stage. It decodes the fetched instruction and owns the 8×16 register file, which is written back from WB. It also performs load-use hazard detection and holds the ID/EX pipeline register, which drives every `*_pipe_2` operand and control input that execute consumes.

## Interface
Parameters:
- `DATA_W`, 16: datapath width.
- `REG_N`, 8: register count; address width is 3.

Ports:
- `clk`  in  1  rising-edge clock. One clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `instr_pipe_1`  in  16  instruction from IF/ID.
- `pc_plus_2_pipe_1`  in  16  PC+2 from IF/ID.
- `flush`  in  1  branch taken in EX/MEM; load a bubble into ID/EX.
- `regWrite_wb`, `write_reg_wb[2:0]`, `write_data_wb[15:0]`  in  write-back port.
- `stall`  out  1  combinational; freezes the PC and IF/ID.
- `pc_plus_2_out_pipe_2`, `read_data_1_out_pipe_2`, `read_data_2_out_pipe_2`, `sign_extended_imm_out_pipe_2`  out  16 each  registered.
- `rs_pipe_2`, `rt_pipe_2`, `rd_pipe_2`  out  3 each  registered.
- `aluSrc`, `regDst`, `memRead`, `memWrite`, `memToReg`, `regWrite`, `branch`  out  1 each  registered.
- `aluOp`  out  2  registered.

## Operation
Instruction fields:
- opcode `[15:12]`, rs `[11:9]`, rt `[8:6]`, rd `[5:3]`, funct `[2:0]`.
- imm6 `[5:0]` is sign-extended to 16 bits: bit 5 is replicated into bits 15:6.

Decode table (fields not listed are 0):
- `0000` R-type: `regDst=1 regWrite=1 aluOp=10`.
- `0100` addi: `aluSrc=1 regWrite=1 aluOp=00`.
- `1011` lw: `aluSrc=1 memRead=1 memToReg=1 regWrite=1 aluOp=00`.
- `1111` sw: `aluSrc=1 memWrite=1 aluOp=00`.
- `1000` beq: `branch=1 aluOp=01`.
- Any other opcode: NOP, all controls 0.

Register file:
- r0 reads as 0; writes to r0 are discarded.
- Writes take effect on the rising edge when `regWrite_wb=1`.
- Write-through bypass: if `regWrite_wb=1`, `write_reg_wb!=0` and `write_reg_wb` equals the read address, the read port returns `write_data_wb` in the same cycle.

Hazard unit (combinational), load-use condition:
- ID/EX `memRead=1`, and `rt_pipe_2 != 0`, and
- `rt_pipe_2 == rs`, or (`rt_pipe_2 == rt` and opcode ∈ {R-type, sw, beq}).

Priority on each edge:
- `flush=1`: ID/EX loads a bubble (all controls 0, data fields 0) and `stall=0`. Flush overrides load-use.
- Otherwise, if load-use is true: `stall=1` and ID/EX loads a bubble. IF/ID re-presents the same instruction next cycle.
- Otherwise ID/EX loads the decoded instruction, the register reads, sign-extended imm, rs/rt/rd and `pc_plus_2_pipe_1`.

## Timing
- ID/EX latency is 1 cycle: values presented before edge N appear on the `*_pipe_2` outputs after edge N.
- `stall` depends only on the current `instr_pipe_1` and the ID/EX contents. It has no dependence on the WB inputs.
- A load-use stall lasts exactly 1 cycle. After the bubble, ID/EX `memRead=0`, so the condition clears.
- Reset (`rst_n=0`), asynchronous and at any time, including mid-stall:
  - all ID/EX outputs go to 0, which makes the stage a NOP;
  - all registers r0–r7 go to 0;
  - `stall` goes to 0.
- First capture after reset deassertion is on the next rising edge.
- WB write and ID read of the same register in one cycle: the read returns the new value (bypass) and the array updates on the edge.
- A write to r0 concurrent with a read of r0 returns 0.

## Test plan
- Reset: assert `rst_n=0` mid-cycle -> all outputs 0 immediately; registers read 0 afterwards.
- R-type: WB writes r1=3, then r2=1. Then `instr=0x0298` (add r3,r1,r2) with `pc_plus_2_pipe_1=2` -> next cycle:
  - `read_data_1=3`, `read_data_2=1`, `rd_pipe_2=3`, `rt_pipe_2=2`;
  - `regDst=1 regWrite=1 aluOp=10 aluSrc=0`;
  - `pc_plus_2_out_pipe_2=2`.
- lw with negative imm: `instr=0xB2BE` (lw r2,-2(r1)) -> `sign_extended_imm=0xFFFE`, `aluSrc=1 memRead=1 memToReg=1`.
- Bypass: same-cycle WB of r1=0x1234 while decoding add r3,r1,r2 -> `read_data_1=0x1234`. Repeat targeting r0 -> reads 0, and r0 stays 0.
- Load-use: lw r2 followed by add r3,r1,r2 -> `stall=1` for one cycle and a bubble enters ID/EX (all controls 0). The add issues on the next cycle.
- Flush vs stall: drive the same load-use case with `flush=1` -> `stall=0` and ID/EX holds a bubble.
